pipeline_stall_controller: RTL

- Central stall/flush sequencer for the 5-stage semiMIPS pipeline.
- Merges three sources into one set of pipeline-control enables:
  - load-use bubble requests from the hazard detection unit;
  - occupancy of the multi-cycle MULT/DIV unit, tracked internally;
  - branch-taken flushes from EX.
- Drives PC enable, IF/ID enable/flush, the ID/EX NOP-insert select, and the MULT/DIV start pulse.

---
 rtl/pipectrl_pkg.sv | 13 +
 rtl/md_occupancy_counter.sv | 39 +++
 rtl/pipeline_stall_controller.sv | 116 +++++++++++
 3 files changed

// File: rtl/pipectrl_pkg.sv
// Shared definitions for the semiMIPS pipeline stall/flush controller:
// MULT/DIV occupancy state encoding and default latency/counter width.
package pipectrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam int MDLAT_DEF  = 32;
  localparam int MDCNTW_DEF = 6;

endpackage : pipectrl_pkg

// File: rtl/md_occupancy_counter.sv
// MULT/DIV occupancy down-counter: loads MDLAT on a start and counts to zero,
// flagging the final occupied cycle so the controller can release the stall.
module md_occupancy_counter
  import pipectrl_pkg::*;
#(
  parameter int MDLAT  = MDLAT_DEF,
  parameter int MDCNTW = MDCNTW_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy,
  output logic last
);

  logic [MDCNTW-1:0] cnt_q;
  logic [MDCNTW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = MDCNTW'(MDLAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - MDCNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign last = (cnt_q == MDCNTW'(1));

endmodule : md_occupancy_counter

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer merging load-use, MULT/DIV occupancy and branch flushes.
// Optional performance counters (stallcnt/flushcnt) are enabled by PIPECTRL_PERF_EN.
module pipeline_stall_controller
  import pipectrl_pkg::*;
#(
  parameter int MDLAT  = MDLAT_DEF,
  parameter int MDCNTW = MDCNTW_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        loaduse,
  input  logic        mdreq,
  input  logic        hilord,
  input  logic        brtaken,
  output logic        pcen,
  output logic        ifiden,
  output logic        ifidflush,
  output logic        ctrlsig,
  output logic        mdstart,
`ifdef PIPECTRL_PERF_EN
  output logic [31:0] stallcnt,
  output logic [31:0] flushcnt,
`endif
  output logic        mdbusy
);

  md_state_e state_q;
  md_state_e state_d;
  logic      md_busy;
  logic      md_last;
  logic      stall;

  md_occupancy_counter #(
    .MDLAT  (MDLAT),
    .MDCNTW (MDCNTW)
  ) u_md_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (mdstart),
    .busy  (md_busy),
    .last  (md_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (mdstart) state_d = BUSY;
      BUSY: if (md_last || !md_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall = loaduse | ((state_q == BUSY) & (mdreq | hilord));

  // if/else (not ?:) so an X on brtaken or stall falls through to the run defaults.
  always_comb begin
    pcen      = 1'b1;
    ifiden    = 1'b1;
    ifidflush = 1'b0;
    ctrlsig   = 1'b0;
    mdstart   = 1'b0;
    if (!rst_n) begin
      mdstart = 1'b0;
    end else if (brtaken) begin
      ifidflush = 1'b1;
      ctrlsig   = 1'b1;
    end else if (stall) begin
      pcen    = 1'b0;
      ifiden  = 1'b0;
      ctrlsig = 1'b1;
    end else begin
      mdstart = mdreq & (state_q == IDLE);
    end
  end

  assign mdbusy = (state_q == BUSY);

`ifdef PIPECTRL_PERF_EN
  logic        stall_act;
  logic [31:0] stallcnt_q;
  logic [31:0] stallcnt_d;
  logic [31:0] flushcnt_q;
  logic [31:0] flushcnt_d;

  assign stall_act = !brtaken && stall;

  always_comb begin
    stallcnt_d = stallcnt_q;
    flushcnt_d = flushcnt_q;
    if (stall_act) stallcnt_d = stallcnt_q + 32'd1;
    if (brtaken)   flushcnt_d = flushcnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallcnt_q <= '0;
      flushcnt_q <= '0;
    end else begin
      stallcnt_q <= stallcnt_d;
      flushcnt_q <= flushcnt_d;
    end
  end

  assign stallcnt = stallcnt_q;
  assign flushcnt = flushcnt_q;
`endif

endmodule : pipeline_stall_controller
